// File: rtl/inv_rr_arbiter_pkg.sv
// Shared types and helpers for the round-robin shared-inverter arbiter.
// Optional statistics counter enabled by defining INV_ARB_STATS_EN.
package inv_arb_pkg;

    localparam int STATS_W = 16;

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_t;

    function automatic int idw(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/inv_rr_arbiter_if.sv
// Request/response bundle between requesters, arbiter and consumer.
// slave: arbiter side; master: requester/consumer side.
interface inv_arb_if
    import inv_arb_pkg::*;
#(
    parameter int N = 4
) ();
    localparam int IDW = idw(N);

    logic [N-1:0]   req_valid;
    logic [N-1:0]   req_a;
    logic [N-1:0]   req_inv;
    logic [N-1:0]   req_ready;
    logic           rsp_valid;
    logic           rsp_y;
    logic [IDW-1:0] rsp_id;
    logic           rsp_ready;

    modport slave (
        input  req_valid, req_a, req_inv, rsp_ready,
        output req_ready, rsp_valid, rsp_y, rsp_id
    );

    modport master (
        output req_valid, req_a, req_inv, rsp_ready,
        input  req_ready, rsp_valid, rsp_y, rsp_id
    );
endinterface

// File: rtl/inv_rr_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr.
// Scans offsets from the highest down so the lowest offset wins last.
module rr_pick
    import inv_arb_pkg::*;
#(
    parameter int N = 4,
    localparam int IDW = idw(N)
) (
    input  logic [N-1:0]   req_i,
    input  logic [IDW-1:0] ptr_i,
    output logic [N-1:0]   onehot_o,
    output logic [IDW-1:0] idx_o,
    output logic           any_o
);

    int j;

    // Rotate-scan the request vector starting at the pointer
    always_comb begin
        onehot_o = '0;
        idx_o    = '0;
        any_o    = |req_i;
        j        = 0;
        for (int k = N - 1; k >= 0; k--) begin
            j = int'(ptr_i) + k;
            if (j >= N) j = j - N;
            if (req_i[j]) begin
                onehot_o    = '0;
                onehot_o[j] = 1'b1;
                idx_o       = IDW'(j);
            end
        end
    end

endmodule

// File: rtl/inv_rr_arbiter.sv
// Shares one conditional inverter among N requesters, round-robin.
// Define INV_ARB_STATS_EN to add the 16-bit grant_cnt accept counter.
module inv_rr_arbiter
    import inv_arb_pkg::*;
#(
    parameter int N = 4,
    localparam int IDW = idw(N)
) (
    input  logic               clk,
    input  logic               rst_n,
`ifdef INV_ARB_STATS_EN
    output logic [STATS_W-1:0] grant_cnt,
`endif
    inv_arb_if.slave           bus
);

    slot_state_t    state_q, state_d;
    logic           y_q, y_d;
    logic [IDW-1:0] id_q, id_d;
    logic [IDW-1:0] ptr_q, ptr_d;
    logic [N-1:0]   onehot;
    logic [IDW-1:0] g;
    logic           any;
    logic           out_free;
    logic           accept;

    rr_pick #(.N(N)) u_pick (
        .req_i    (bus.req_valid),
        .ptr_i    (ptr_q),
        .onehot_o (onehot),
        .idx_o    (g),
        .any_o    (any)
    );

    // Output slot, result and pointer registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= SLOT_EMPTY;
            y_q     <= 1'b0;
            id_q    <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            y_q     <= y_d;
            id_q    <= id_d;
            ptr_q   <= ptr_d;
        end
    end

    // Grant decision and next state; grants are gated off during reset
    always_comb begin
        out_free = (state_q == SLOT_EMPTY) | bus.rsp_ready;
        accept   = out_free & any & rst_n;
        state_d  = state_q;
        y_d      = y_q;
        id_d     = id_q;
        ptr_d    = ptr_q;
        if (out_free) begin
            state_d = accept ? SLOT_FULL : SLOT_EMPTY;
        end
        if (accept) begin
            y_d   = bus.req_a[g] ^ bus.req_inv[g];
            id_d  = g;
            ptr_d = (g == IDW'(N - 1)) ? '0 : g + 1'b1;
        end
    end

    assign bus.req_ready = accept ? onehot : '0;
    assign bus.rsp_valid = (state_q == SLOT_FULL);
    assign bus.rsp_y     = y_q;
    assign bus.rsp_id    = id_q;

`ifdef INV_ARB_STATS_EN
    logic [STATS_W-1:0] cnt_q;

    // Accept counter, wraps naturally at 16 bits
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else if (accept) cnt_q <= cnt_q + 1'b1;
    end

    assign grant_cnt = cnt_q;
`endif

endmodule
